// File: rtl/axi_master_arbiter_if.sv
// Bundles the requester command/response signals and the single-beat master
// command port shared by axi_master_arbiter.
//   req_valid/req_write/req_addr/req_wdata : per-requester commands (packed)
//   req_ready/rsp_valid                    : one-hot accept / completion pulses
//   rsp_rdata/rsp_err                      : response payload, valid with rsp_valid
//   busy                                   : arbiter not idle
//   mst_*                                  : start/done handshake to the master
// Modports: slave = arbiter side, master = requesters plus the master engine.
interface axi_master_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         mst_addr;
  logic [DATA_WIDTH-1:0]         mst_write_data;
  logic                          mst_start_write;
  logic                          mst_start_read;
  logic                          mst_done;
  logic [DATA_WIDTH-1:0]         mst_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mst_done, mst_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mst_addr, mst_write_data, mst_start_write, mst_start_read
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mst_done, mst_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mst_addr, mst_write_data, mst_start_write, mst_start_read
  );
endinterface

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one single-beat master command port between
// NUM_REQ requesters. One transaction in flight; the master is driven with a
// one-cycle start pulse and completion is detected as done falling then
// rising again. A bounded wait produces an error response.
// Ports:
//   M_AXI_ACLK    : clock
//   M_AXI_ARESETN : asynchronous active-low reset
//   bus           : axi_master_arbiter_if.slave (requesters + master handshake)
module axi_master_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 M_AXI_ARESETN,
  axi_master_arbiter_if.slave  bus
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GW-1:0]      LAST_IDX = GW'(NUM_REQ - 1);
  localparam logic [TW-1:0]      TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_e;

  state_e                 state_q,      state_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GW-1:0]          win_q,        win_d;
  logic                   write_q,      write_d;
  logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q,      wdata_d;
  logic [NUM_REQ-1:0]     req_ready_q,  req_ready_d;
  logic [NUM_REQ-1:0]     rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q,  rsp_rdata_d;
  logic                   rsp_err_q,    rsp_err_d;
  logic                   start_wr_q,   start_wr_d;
  logic                   start_rd_q,   start_rd_d;
  logic [TW-1:0]          tmo_q,        tmo_d;
  logic                   busy_q;

  logic                   pick_vld;
  logic [GW-1:0]          pick_idx;
  logic [TW-1:0]          tmo_inc;
  logic                   tmo_hit;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld && bus.req_valid[GW'((32'(last_grant_q) + k) % NUM_REQ)]) begin
        pick_vld = 1'b1;
        pick_idx = GW'((32'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  // Saturating wait counter; a disabled timeout never fires.
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_MAX);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    start_wr_d   = 1'b0;
    start_rd_d   = 1'b0;
    tmo_d        = tmo_q;

    unique case (state_q)
      IDLE: begin
        // A low done means the master is busy with someone else's command.
        if (bus.mst_done && pick_vld) begin
          win_d       = pick_idx;
          write_d     = bus.req_write[pick_idx];
          addr_d      = bus.req_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = bus.req_wdata[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
          req_ready_d = ONE_HOT0 << pick_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        start_wr_d = write_q;
        start_rd_d = !write_q;
        tmo_d      = '0;
        state_d    = WAIT_LOW;
      end
      WAIT_LOW, WAIT_HIGH: begin
        // A genuine completion wins over a simultaneous timeout.
        if (state_q == WAIT_HIGH && bus.mst_done) begin
          rsp_rdata_d  = write_q ? '0 : bus.mst_read_data;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = ONE_HOT0 << win_q;
          last_grant_d = win_q;
          state_d      = IDLE;
        end else if (tmo_hit) begin
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = ONE_HOT0 << win_q;
          last_grant_d = win_q;
          tmo_d        = tmo_inc;
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (state_q == WAIT_LOW && !bus.mst_done) begin
            state_d = WAIT_HIGH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_IDX;
      win_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      start_wr_q   <= 1'b0;
      start_rd_q   <= 1'b0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      start_wr_q   <= start_wr_d;
      start_rd_q   <= start_rd_d;
      tmo_q        <= tmo_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.busy            = busy_q;
  assign bus.mst_addr        = addr_q;
  assign bus.mst_write_data  = wdata_q;
  assign bus.mst_start_write = start_wr_q;
  assign bus.mst_start_read  = start_rd_q;

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Shares one axi_master command port between NUM_REQ requesters (e.g. DFR reservoir loader, readout engine, host config path).
- Accepts single-beat read/write commands and grants the master round-robin, one transaction at a time.
- Sequences the master's start/done handshake and returns read data, or a timeout error, to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, command address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 1024, maximum cycles waiting on the master before an error response; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid; held until accepted
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high in any state other than IDLE
- mst_addr  out  ADDR_WIDTH  to master addr
- mst_write_data  out  DATA_WIDTH  to master write_data
- mst_start_write  out  1  to master start_write
- mst_start_read  out  1  to master start_read
- mst_done  in  1  from master done (high = master idle)
- mst_read_data  in  DATA_WIDTH  from master read_data

Behaviour:
- Reset (M_AXI_ARESETN = 0, asynchronous):
  - State goes to IDLE.
  - req_ready, rsp_valid, rsp_rdata, rsp_err, mst_start_* and mst_addr/mst_write_data are all 0.
  - Grant pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Timeout counter = 0.
  - An in-flight transaction is dropped with no response. mst_start_* low guarantees no new master command.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - Acts only when mst_done = 1 and any req_valid bit is high.
  - Winner = first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch the winner's addr, wdata, write and index; pulse req_ready[winner]; go to ISSUE.
  - If mst_done = 0, no grant is made (master busy from an external source).
- ISSUE:
  - Assert exactly one of mst_start_write / mst_start_read for exactly one cycle.
  - mst_addr and mst_write_data equal the latched values; they stay stable from ISSUE until return to IDLE.
  - Go to WAIT_LOW.
- WAIT_LOW: wait for mst_done = 0 (master left its ready state), then go to WAIT_HIGH.
- WAIT_HIGH: wait for mst_done = 1. On that cycle:
  - rsp_rdata <= mst_read_data for reads, 0 for writes.
  - rsp_err <= 0; pulse rsp_valid[winner]; last_grant <= winner; go to IDLE.
- Timeout:
  - Counter clears on entry to WAIT_LOW and increments each cycle in WAIT_LOW/WAIT_HIGH.
  - When it reaches TIMEOUT_CYCLES (nonzero), return to IDLE with rsp_valid[winner], rsp_err = 1, rsp_rdata = 0, and last_grant updated.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it never wraps.
- rsp_rdata and rsp_err hold their value until the next response.
- Simultaneous events:
  - A requester whose response pulses may reassert req_valid in the same cycle. It is considered in IDLE on the next cycle and loses to any other pending requester (round-robin).
  - req_valid dropping before acceptance withdraws the request; there is no error.
- Minimum command-to-response time: accept T, start T+1, then master latency, then +1 registered response.
- Throughput: one transaction in flight; at least 1 IDLE cycle between transactions.

Test Plan:
- Single read by requester 0 to addr 0x10; master model drops done the cycle after start and returns 0xDEADBEEF after 4 cycles -> req_ready[0] at T, mst_start_read at T+1 with mst_addr=0x10, rsp_valid[0] with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Single write by requester 1, addr 0x24, data 0x12345678 -> mst_start_write one cycle, mst_write_data=0x12345678, rsp_valid[1], rsp_rdata=0.
- Both requesters hold req_valid continuously for 4 transactions -> grants strictly alternate 0,1,0,1; never two req_ready bits in one cycle.
- Master model never drops done, with TIMEOUT_CYCLES=16 -> rsp_valid with rsp_err=1 exactly 16 cycles after entering WAIT_LOW; the next request is then served normally.
- Assert reset in WAIT_HIGH -> all outputs 0 immediately; no rsp_valid pulse; after release, requester 0 wins first.
- mst_done held low externally with req_valid[0]=1 -> no req_ready until mst_done=1; grant follows on the next cycle.
